// File: rtl/risk_pkg.sv
// Shared constants, FSM state encoding and lane/bank/row slicing helpers
// for the RISK strided tile sequencer.
package risk_pkg;
    localparam int LANES   = 16;
    localparam int BITS    = 18;
    localparam int LOGBANK = 5;
    localparam int AW      = 15;
    localparam int SW      = 14;
    localparam int PCW     = 5;
    localparam int TILE_W  = LANES * BITS;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_PASS  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    typedef logic [AW-1:0]         addr_t;
    typedef logic [LOGBANK-1:0]    bank_t;
    typedef logic [AW-LOGBANK-1:0] row_t;

    function automatic bank_t addr_bank(input addr_t a);
        return a[LOGBANK-1:0];
    endfunction

    function automatic row_t addr_row(input addr_t a);
        return a[AW-1:LOGBANK];
    endfunction

    function automatic logic [BITS-1:0] lane_get(input logic [TILE_W-1:0] v, input int l);
        return v[BITS*l +: BITS];
    endfunction
endpackage

// File: rtl/risk_tile_sched_if.sv
// Command, memory-pass and response signals of the tile sequencer.
// slave is the sequencer's view; master is the register-file/memory side.
interface risk_tile_sched_if;
    import risk_pkg::*;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_we;
    logic [AW-1:0]          cmd_addr;
    logic [SW-1:0]          cmd_stride_x;
    logic [SW-1:0]          cmd_stride_y;
    logic [TILE_W-1:0]      cmd_wdata;
    logic                   mem_en;
    logic                   mem_we;
    logic [LANES-1:0]       mem_lane_mask;
    logic [LANES*AW-1:0]    mem_addrs;
    logic [TILE_W-1:0]      mem_wdata;
    logic [TILE_W-1:0]      mem_rdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [TILE_W-1:0]      rsp_data;
    logic [PCW-1:0]         rsp_passes;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_stride_x, cmd_stride_y, cmd_wdata,
        output mem_rdata, rsp_ready,
        input  cmd_ready, mem_en, mem_we, mem_lane_mask, mem_addrs, mem_wdata,
        input  rsp_valid, rsp_data, rsp_passes
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_stride_x, cmd_stride_y, cmd_wdata,
        input  mem_rdata, rsp_ready,
        output cmd_ready, mem_en, mem_we, mem_lane_mask, mem_addrs, mem_wdata,
        output rsp_valid, rsp_data, rsp_passes
    );
endinterface

// File: rtl/risk_bank_pick.sv
// Combinational greedy bank arbiter: one lane per bank per pass,
// lowest-numbered pending lane wins.
module risk_bank_pick
    import risk_pkg::*;
(
    input  logic [LANES-1:0]         pending,
    input  logic [LANES*LOGBANK-1:0] banks,
    output logic [LANES-1:0]         sel
);
    logic [(1 << LOGBANK)-1:0] claimed_s;

    // Walk lanes upward; a lane is taken only if its bank is still free.
    always_comb begin
        claimed_s = '0;
        sel       = '0;
        for (int l = 0; l < LANES; l++) begin
            if (pending[l] && !claimed_s[banks[LOGBANK*l +: LOGBANK]]) begin
                sel[l]                                  = 1'b1;
                claimed_s[banks[LOGBANK*l +: LOGBANK]] = 1'b1;
            end else begin
                sel[l] = 1'b0;
            end
        end
    end
endmodule

// File: rtl/risk_tile_sched.sv
// Turns one 4x4 strided tile command into bank-conflict-free memory passes
// and merges returned load lanes into a single tile response.
module risk_tile_sched
    import risk_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    risk_tile_sched_if.slave bus
);
    state_t                 state_r;
    logic                   we_r;
    addr_t                  base_r;
    logic [SW-1:0]          sx_r;
    logic [SW-1:0]          sy_r;
    logic [LANES-1:0]       pending_r;
    logic [LANES*AW-1:0]    lane_addr_s;
    logic [LANES*AW-1:0]    lane_addr_r;
    logic [LANES*LOGBANK-1:0] pick_banks_s;
    logic [LANES-1:0]       pick_sel_s;
    logic                   issue_s;
    logic [PCW-1:0]         pass_cnt_r;
    logic [TILE_W-1:0]      tile_r;
    logic [TILE_W-1:0]      mem_wdata_r;
    logic [MEM_LAT-1:0]     sr_valid_r;
    logic [MEM_LAT-1:0]     sr_early_s;
    logic [LANES-1:0]       sr_mask_r [MEM_LAT];
    logic                   cmd_ready_r;
    logic                   mem_en_r;
    logic                   mem_we_r;
    logic [LANES-1:0]       mem_mask_r;
    logic                   rsp_valid_r;
    logic [PCW-1:0]         rsp_passes_r;

    // Lane l = y*4+x sits at base + sx*x + sy*y, wrapping in AW bits.
    always_comb begin
        lane_addr_s = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_addr_s[AW*l +: AW] = base_r + addr_t'(sx_r) * addr_t'(l % 4)
                                             + addr_t'(sy_r) * addr_t'(l / 4);
        end
    end

    // The first pass is picked while addresses are still being registered.
    always_comb begin
        pick_banks_s = '0;
        for (int l = 0; l < LANES; l++) begin
            if (state_r == ST_ADDR) begin
                pick_banks_s[LOGBANK*l +: LOGBANK] = addr_bank(lane_addr_s[AW*l +: AW]);
            end else begin
                pick_banks_s[LOGBANK*l +: LOGBANK] = addr_bank(lane_addr_r[AW*l +: AW]);
            end
        end
    end

    // A pass goes out on the ADDR exit edge and on every PASS edge with work left.
    always_comb begin
        if (state_r == ST_ADDR) begin
            issue_s = 1'b1;
        end else if ((state_r == ST_PASS) && (pending_r != '0)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Return pipeline is done once only the last stage (merging now) can be valid.
    always_comb begin
        sr_early_s              = sr_valid_r;
        sr_early_s[MEM_LAT-1]   = 1'b0;
    end

    risk_bank_pick u_pick (
        .pending (pending_r),
        .banks   (pick_banks_s),
        .sel     (pick_sel_s)
    );

    // Sequencer FSM, pass issue, read-return pipeline and tile merge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            we_r         <= 1'b0;
            base_r       <= '0;
            sx_r         <= '0;
            sy_r         <= '0;
            pending_r    <= '0;
            lane_addr_r  <= '0;
            pass_cnt_r   <= '0;
            tile_r       <= '0;
            mem_wdata_r  <= '0;
            sr_valid_r   <= '0;
            for (int k = 0; k < MEM_LAT; k++) begin
                sr_mask_r[k] <= '0;
            end
            cmd_ready_r  <= 1'b1;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_mask_r   <= '0;
            rsp_valid_r  <= 1'b0;
            rsp_passes_r <= '0;
        end else begin
            sr_valid_r[0] <= mem_en_r & ~mem_we_r;
            sr_mask_r[0]  <= mem_mask_r;
            for (int k = 1; k < MEM_LAT; k++) begin
                sr_valid_r[k] <= sr_valid_r[k-1];
                sr_mask_r[k]  <= sr_mask_r[k-1];
            end
            if (sr_valid_r[MEM_LAT-1]) begin
                for (int l = 0; l < LANES; l++) begin
                    if (sr_mask_r[MEM_LAT-1][l]) begin
                        tile_r[BITS*l +: BITS] <= lane_get(bus.mem_rdata, l);
                    end
                end
            end

            if (issue_s) begin
                mem_en_r   <= 1'b1;
                mem_we_r   <= we_r;
                mem_mask_r <= pick_sel_s;
                pending_r  <= pending_r & ~pick_sel_s;
                pass_cnt_r <= pass_cnt_r + 5'd1;
            end else begin
                mem_en_r   <= 1'b0;
                mem_we_r   <= 1'b0;
                mem_mask_r <= '0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_r) begin
                        cmd_ready_r <= 1'b0;
                        we_r        <= bus.cmd_we;
                        base_r      <= bus.cmd_addr;
                        sx_r        <= bus.cmd_stride_x;
                        sy_r        <= bus.cmd_stride_y;
                        mem_wdata_r <= bus.cmd_wdata;
                        tile_r      <= '0;
                        pending_r   <= '1;
                        pass_cnt_r  <= '0;
                        state_r     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    lane_addr_r <= lane_addr_s;
                    state_r     <= ST_PASS;
                end
                ST_PASS: begin
                    if (pending_r == '0) begin
                        if (we_r) begin
                            rsp_valid_r  <= 1'b1;
                            rsp_passes_r <= pass_cnt_r;
                            state_r      <= ST_RESP;
                        end else begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (sr_early_s == '0) begin
                        rsp_valid_r  <= 1'b1;
                        rsp_passes_r <= pass_cnt_r;
                        state_r      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready     = cmd_ready_r;
    assign bus.mem_en        = mem_en_r;
    assign bus.mem_we        = mem_we_r;
    assign bus.mem_lane_mask = mem_mask_r;
    assign bus.mem_addrs     = lane_addr_r;
    assign bus.mem_wdata     = mem_wdata_r;
    assign bus.rsp_valid     = rsp_valid_r;
    assign bus.rsp_data      = tile_r;
    assign bus.rsp_passes    = rsp_passes_r;
endmodule
